// File: rtl/feedback_loop_diff.sv
// feedback_loop_diff: streaming first difference y[n] = s[n] - s[n-1] (mod 2^DATA_W),
// the inverse of the wrapping running-sum accumulator. Valid/ready on both sides,
// a 2-entry registered output buffer, a clear command and an accepted-sample counter.
//
// Buffer states (the state value is the occupancy count):
//   state | meaning
//   EMPTY | no buffered differences, out_valid low
//   ONE   | one difference buffered, can push and pop in the same cycle
//   FULL  | two differences buffered, in_ready low until a pop
module feedback_loop_diff #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic              clear_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  sample_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  buf_state_e        state_q, state_d;
  logic              ready_en_q;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              push;
  logic              pop;

  // ready_en_q keeps in_ready low until the first edge after reset release
  assign in_ready   = ready_en_q && system1000_rstn && (state_q != FULL) && !clear_i;
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = mem_q[rd_ptr_q];
  assign sample_cnt = cnt_q;
  assign push       = in_valid && in_ready;
  // a pop coinciding with clear is dropped together with the buffer contents
  assign pop        = out_valid && out_ready && !clear_i;
  // plain wrapping subtraction undoes the wrapping add exactly
  assign diff       = in_data - prev_q;

  // next buffer state from push/pop, clear forces EMPTY
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (clear_i) state_d = EMPTY;
  end

  // state register, buffer storage, history and counter
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      state_q    <= EMPTY;
      ready_en_q <= 1'b0;
      prev_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (clear_i) begin
        prev_q   <= '0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= diff;
          wr_ptr_q        <= ~wr_ptr_q;
          prev_q          <= in_data;
          cnt_q           <= cnt_q + CNT_W'(1);
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule
